// File: rtl/irq_injector.sv
// rtl/irq_injector.sv - per-channel address/force triggered interrupt pulse generator; optional DELAY state under IRQ_INJ_DELAY_EN
module irq_injector #(
  parameter int NCH  = 6,
  parameter int AW   = 32,
  parameter int LENW = 8,
  parameter int CNTW = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [AW-1:0]    i_addr,
  input  logic [NCH-1:0]   i_force,
  input  logic             i_cfg_we,
  input  logic [2:0]       i_cfg_ch,
  input  logic             i_cfg_en,
  input  logic [AW-1:0]    i_cfg_addr,
  input  logic [LENW-1:0]  i_cfg_len,
  input  logic [CNTW-1:0]  i_cfg_limit,
  input  logic [LENW-1:0]  i_cfg_delay,
  output logic [NCH-1:0]   o_irq,
  output logic             o_irq_any,
  output logic [NCH-1:0]   o_busy
);

`ifdef IRQ_INJ_DELAY_EN
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_ACTIVE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE} state_t;
`endif

  state_t            r_state     [NCH];
  state_t            w_state     [NCH];
  state_t            w_entry_st  [NCH];
  logic              r_en        [NCH];
  logic              w_en        [NCH];
  logic [AW-1:0]     r_trig_addr [NCH];
  logic [AW-1:0]     w_trig_addr [NCH];
  logic [LENW-1:0]   r_len       [NCH];
  logic [LENW-1:0]   w_len       [NCH];
  logic [CNTW-1:0]   r_limit     [NCH];
  logic [CNTW-1:0]   w_limit     [NCH];
  logic [CNTW-1:0]   r_fired     [NCH];
  logic [CNTW-1:0]   w_fired     [NCH];
  logic              r_pending   [NCH];
  logic              w_pending   [NCH];
  logic [LENW-1:0]   r_cnt       [NCH];
  logic [LENW-1:0]   w_cnt       [NCH];
  logic [LENW-1:0]   w_entry_cnt [NCH];
  logic              w_hit       [NCH];
  logic [NCH-1:0]    r_irq;
  logic [NCH-1:0]    w_irq;
  logic              r_irq_any;

`ifdef IRQ_INJ_DELAY_EN
  logic [LENW-1:0]   r_delay     [NCH];
  logic [LENW-1:0]   w_delay     [NCH];
`else
  logic              w_unused_delay;
  assign w_unused_delay = ^i_cfg_delay;
`endif

  // next-state: triggers, countdowns, pending re-fire, config write override
  always_comb begin
    w_irq = '0;
    for (int i = 0; i < NCH; i++) begin
      w_state[i]     = r_state[i];
      w_en[i]        = r_en[i];
      w_trig_addr[i] = r_trig_addr[i];
      w_len[i]       = r_len[i];
      w_limit[i]     = r_limit[i];
      w_fired[i]     = r_fired[i];
      w_pending[i]   = r_pending[i];
      w_cnt[i]       = r_cnt[i];
`ifdef IRQ_INJ_DELAY_EN
      w_delay[i]     = r_delay[i];
      if (r_delay[i] != '0) begin
        w_entry_st[i]  = S_DELAY;
        w_entry_cnt[i] = r_delay[i];
      end else begin
        w_entry_st[i]  = S_ACTIVE;
        w_entry_cnt[i] = r_len[i];
      end
`else
      w_entry_st[i]  = S_ACTIVE;
      w_entry_cnt[i] = r_len[i];
`endif
      w_hit[i] = (i_addr == r_trig_addr[i]) &&
                 ((r_limit[i] == '0) || (r_fired[i] < r_limit[i]));

      case (r_state[i])
        S_ARMED: begin
          if (r_en[i] && (w_hit[i] || i_force[i])) begin
            w_state[i] = w_entry_st[i];
            w_cnt[i]   = w_entry_cnt[i];
            if (w_hit[i] && (r_fired[i] != '1))
              w_fired[i] = r_fired[i] + CNTW'(1);
          end
        end
`ifdef IRQ_INJ_DELAY_EN
        S_DELAY: begin
          if (i_force[i])
            w_pending[i] = 1'b1;
          if (r_cnt[i] <= LENW'(1)) begin
            w_state[i] = S_ACTIVE;
            w_cnt[i]   = r_len[i];
          end else begin
            w_cnt[i]   = r_cnt[i] - LENW'(1);
          end
        end
`endif
        S_ACTIVE: begin
          if (r_cnt[i] == '0) begin
            if (r_pending[i] || i_force[i]) begin
              w_pending[i] = 1'b0;
              w_state[i]   = w_entry_st[i];
              w_cnt[i]     = w_entry_cnt[i];
            end else begin
              w_state[i]   = S_ARMED;
            end
          end else begin
            w_cnt[i] = r_cnt[i] - LENW'(1);
            if (i_force[i])
              w_pending[i] = 1'b1;
          end
        end
        default: begin
          w_state[i] = S_IDLE;
        end
      endcase

      if (i_cfg_we && (i_cfg_ch == 3'(i))) begin
        w_en[i]        = i_cfg_en;
        w_trig_addr[i] = i_cfg_addr;
        w_len[i]       = i_cfg_len;
        w_limit[i]     = i_cfg_limit;
        w_fired[i]     = '0;
        w_pending[i]   = 1'b0;
        w_state[i]     = i_cfg_en ? S_ARMED : S_IDLE;
`ifdef IRQ_INJ_DELAY_EN
        w_delay[i]     = i_cfg_delay;
`endif
      end

      w_irq[i] = (w_state[i] == S_ACTIVE);
    end
  end

  // channel state registers; irq/irq_any registered from next-state
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i]     <= S_IDLE;
        r_en[i]        <= 1'b0;
        r_trig_addr[i] <= '0;
        r_len[i]       <= LENW'(5);
        r_limit[i]     <= CNTW'(1);
        r_fired[i]     <= '0;
        r_pending[i]   <= 1'b0;
        r_cnt[i]       <= '0;
`ifdef IRQ_INJ_DELAY_EN
        r_delay[i]     <= '0;
`endif
      end
      r_irq     <= '0;
      r_irq_any <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i]     <= w_state[i];
        r_en[i]        <= w_en[i];
        r_trig_addr[i] <= w_trig_addr[i];
        r_len[i]       <= w_len[i];
        r_limit[i]     <= w_limit[i];
        r_fired[i]     <= w_fired[i];
        r_pending[i]   <= w_pending[i];
        r_cnt[i]       <= w_cnt[i];
`ifdef IRQ_INJ_DELAY_EN
        r_delay[i]     <= w_delay[i];
`endif
      end
      r_irq     <= w_irq;
      r_irq_any <= |w_irq;
    end
  end

  // busy reflects a channel that is counting toward or driving a pulse
  always_comb begin
    o_busy = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef IRQ_INJ_DELAY_EN
      o_busy[i] = (r_state[i] == S_ACTIVE) || (r_state[i] == S_DELAY);
`else
      o_busy[i] = (r_state[i] == S_ACTIVE);
`endif
    end
  end

  assign o_irq     = r_irq;
  assign o_irq_any = r_irq_any;

endmodule

// File: tb/tb_irq_injector.sv
// tb/tb_irq_injector.sv - scoreboard bench for irq_injector (expected pulse windows queued at stimulus time)
module tb_irq_injector;
  localparam int NCH = 6;
  localparam logic [31:0] IDLE_A = 32'h0000_0100;
`ifdef IRQ_INJ_DELAY_EN
  localparam int DLY = 4;
`else
  localparam int DLY = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     i_addr;
  logic [NCH-1:0]  i_force;
  logic            cfg_we;
  logic [2:0]      cfg_ch;
  logic            cfg_en;
  logic [31:0]     cfg_addr;
  logic [7:0]      cfg_len;
  logic [3:0]      cfg_limit;
  logic [7:0]      cfg_delay;
  logic [NCH-1:0]  o_irq;
  logic            o_irq_any;
  logic [NCH-1:0]  o_busy;

  irq_injector #(.NCH(NCH), .AW(32), .LENW(8), .CNTW(4)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_addr(i_addr), .i_force(i_force),
    .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_en(cfg_en), .i_cfg_addr(cfg_addr),
    .i_cfg_len(cfg_len), .i_cfg_limit(cfg_limit), .i_cfg_delay(cfg_delay),
    .o_irq(o_irq), .o_irq_any(o_irq_any), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int bfirst; int first; int last;} win_t;
  win_t wq[$];
  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    logic [NCH-1:0] e_irq;
    logic [NCH-1:0] e_busy;
    @(posedge clk);
    cyc++;
    #1;
    e_irq  = '0;
    e_busy = '0;
    foreach (wq[k]) begin
      if (cyc >= wq[k].first && cyc <= wq[k].last)  e_irq[wq[k].ch]  = 1'b1;
      if (cyc >= wq[k].bfirst && cyc <= wq[k].last) e_busy[wq[k].ch] = 1'b1;
    end
    while (wq.size() > 0 && wq[0].last < cyc) void'(wq.pop_front());
    check_val("irq", 32'(o_irq), 32'(e_irq));
    check_val("irq_any", 32'(o_irq_any), 32'(|e_irq));
    check_val("busy", 32'(o_busy), 32'(e_busy));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_pulse(input int ch, input int len, input int d);
    win_t w;
    w.ch = ch; w.bfirst = cyc + 1; w.first = cyc + 1 + d; w.last = cyc + 1 + d + len;
    wq.push_back(w);
  endtask

  task automatic cfg(input int ch, input bit en, input logic [31:0] a, input int len,
                     input int limit, input int d);
    foreach (wq[k]) if (wq[k].ch == ch && wq[k].last > cyc) wq[k].last = cyc;
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_en = en; cfg_addr = a;
    cfg_len = 8'(len); cfg_limit = 4'(limit); cfg_delay = 8'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic drive_addr(input logic [31:0] a);
    i_addr = a;
    tick();
    i_addr = IDLE_A;
  endtask

  initial begin
    int base;
    win_t w;
    i_addr = IDLE_A; i_force = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0;
    cfg_addr = '0; cfg_len = '0; cfg_limit = '0; cfg_delay = '0;
    ticks(2);
    #2 rst_n = 1'b1;
    ticks(2);

    // ch0: single limited address fire, second hit ignored
    cfg(0, 1'b1, 32'h302c, 5, 1, DLY);
    ticks(3);
    expect_pulse(0, 5, DLY);
    drive_addr(32'h302c);
    ticks(10 + DLY);
    drive_addr(32'h302c);
    ticks(10 + DLY);

    // ch1: unlimited, len 0, enough hits to saturate fired
    cfg(1, 1'b1, 32'h3000, 0, 0, DLY);
    tick();
    for (int n = 0; n < 18; n++) begin
      expect_pulse(1, 0, DLY);
      drive_addr(32'h3000);
      ticks(2 + DLY);
    end

    // ch2: force, then force during pulse -> back-to-back pulse
    cfg(2, 1'b1, 32'h4000, 3, 1, DLY);
    tick();
    base = cyc;
    expect_pulse(2, 3, DLY);
    i_force[2] = 1'b1; tick(); i_force = '0; tick();
    w.ch = 2; w.bfirst = base + 5 + DLY; w.first = base + 5 + 2 * DLY; w.last = base + 8 + 2 * DLY;
    wq.push_back(w);
    i_force[2] = 1'b1; tick(); i_force = '0;
    ticks(12 + 2 * DLY);
    expect_pulse(2, 3, DLY);
    i_force[2] = 1'b1; tick(); i_force = '0;
    ticks(8 + DLY);

    // ch0: config write aborts a forced pulse; fired reset allows re-trigger
    expect_pulse(0, 5, DLY);
    i_force[0] = 1'b1; tick(); i_force = '0;
    ticks(2 + DLY);
    cfg(0, 1'b1, 32'h302c, 5, 1, DLY);
    cfg(6, 1'b1, 32'h302c, 0, 0, 0);
    tick();
    expect_pulse(0, 5, DLY);
    drive_addr(32'h302c);
    ticks(8 + DLY);

    // ch0: simultaneous address+force is one counted fire, no pending
    cfg(0, 1'b1, 32'h302c, 5, 1, DLY);
    tick();
    expect_pulse(0, 5, DLY);
    i_addr = 32'h302c; i_force[0] = 1'b1; tick(); i_addr = IDLE_A; i_force = '0;
    ticks(10 + DLY);
    drive_addr(32'h302c);
    ticks(8 + DLY);

    // config write beats a same-cycle trigger
    i_force[0] = 1'b1; i_addr = 32'h302c;
    cfg(0, 1'b1, 32'h302c, 2, 1, DLY);
    i_force = '0; i_addr = IDLE_A;
    ticks(3);
    expect_pulse(0, 2, DLY);
    drive_addr(32'h302c);
    ticks(6 + DLY);

    // disabled channel ignores address and force
    cfg(5, 1'b0, 32'h7000, 2, 0, DLY);
    tick();
    i_force[5] = 1'b1; drive_addr(32'h7000); i_force = '0;
    ticks(6 + DLY);

    // ch4: delay 4 / len 1
    cfg(4, 1'b1, 32'h5000, 1, 1, 4);
    tick();
    expect_pulse(4, 1, DLY);
    drive_addr(32'h5000);
    ticks(8);

    // ch3: asynchronous reset mid-pulse
    cfg(3, 1'b1, 32'h6000, 5, 1, DLY);
    tick();
    expect_pulse(3, 5, DLY);
    i_force[3] = 1'b1; tick(); i_force = '0;
    ticks(2 + DLY);
    #3 rst_n = 1'b0;
    #1;
    check_val("rst_irq", 32'(o_irq), 32'h0);
    check_val("rst_irq_any", 32'(o_irq_any), 32'h0);
    check_val("rst_busy", 32'(o_busy), 32'h0);
    wq.delete();
    tick();
    #2 rst_n = 1'b1;
    ticks(2);
    i_force = '1; drive_addr(32'h302c); i_force = '0;
    ticks(8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
